// File: rtl/mul_share_if.sv
// Bundle between requesters, the shared multiplier and the response consumer
// of mul_share_arbiter. The arbiter connects through the slave modport.
interface mul_share_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [WIDTH-1:0]           mul_in1;
  logic [WIDTH-1:0]           mul_in2;
  logic [2*WIDTH-1:0]         mul_out;
  logic                       mul_overflow;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [2*WIDTH-1:0]         rsp_data;
  logic                       rsp_overflow;
  logic [15:0]                ops_done;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_out, mul_overflow,
    output req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_data,
           rsp_overflow, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_out, mul_overflow,
    input  req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_data,
           rsp_overflow, ops_done
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NREQ
// requesters: operand stage (EXEC) followed by a backpressured response stage.
module mul_share_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic       clk,
  input  logic       rst,
  mul_share_if.slave bus
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CNTW = 16;

  typedef enum logic {IDLE, EXEC} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [IDW-1:0]    op_id_q, op_id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [PW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic [CNTW-1:0]   ops_q, ops_d;

  logic              stall_c;
  logic              can_accept_c;
  logic              accept_c;
  logic              load_c;
  logic              grant_vld_c;
  logic [IDW-1:0]    grant_id_c;
  logic [NREQ-1:0]   req_ready_c;

  assign stall_c      = rsp_valid_q & ~bus.rsp_ready;
  assign can_accept_c = (state_q == IDLE) | ~stall_c;
  assign accept_c     = ~rst & can_accept_c & grant_vld_c;
  assign load_c       = (state_q == EXEC) & ~stall_c;

  // First valid requester searching upward from the one after last_q.
  always_comb begin
    int unsigned idx;
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(last_q) + off) % NREQ;
      if (!grant_vld_c && bus.req_valid[IDW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (accept_c) req_ready_c[grant_id_c] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    ops_d       = ops_q;

    case (state_q)
      IDLE:    if (accept_c) state_d = EXEC;
      EXEC:    if (!stall_c) state_d = accept_c ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    // Operand registers are zeroed on the way to IDLE so mul_in* read 0 there.
    if (accept_c) begin
      op_a_d  = bus.req_a[grant_id_c];
      op_b_d  = bus.req_b[grant_id_c];
      op_id_d = grant_id_c;
      last_d  = grant_id_c;
    end else if (load_c) begin
      op_a_d  = '0;
      op_b_d  = '0;
      op_id_d = '0;
    end

    if (load_c) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = op_id_q;
      rsp_data_d  = bus.mul_out;
      rsp_ovf_d   = bus.mul_overflow;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_valid_q && bus.rsp_ready) ops_d = ops_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.mul_in1      = op_a_q;
  assign bus.mul_in2      = op_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.ops_done     = ops_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed per-cycle vector table for mul_share_arbiter with an exact 4x4
// multiplier model, plus reset-mid-flight and counter-wrap sequences.
module tb_mul_share_arbiter;
  logic clk = 1'b1;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_if #(.WIDTH(4), .NREQ(4)) bus ();

  mul_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Exact multiplier; overflow flags a product that does not fit in WIDTH bits.
  assign bus.mul_out      = 8'(bus.mul_in1) * 8'(bus.mul_in2);
  assign bus.mul_overflow = |bus.mul_out[7:4];

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_v;
    logic [1:0]  e_id;
    logic [7:0]  e_data;
    logic        e_ovf;
    logic [15:0] e_ops;
    logic [3:0]  e_in1;
    logic [3:0]  e_in2;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic rdy, input logic [3:0] er,
                              input logic ev, input logic [1:0] eid,
                              input logic [7:0] ed, input logic eo,
                              input logic [15:0] eops,
                              input logic [3:0] ei1, input logic [3:0] ei2);
    vec_t t;
    t.rst = r; t.valid = v; t.a = a; t.b = b; t.rdy = rdy;
    t.e_ready = er; t.e_v = ev; t.e_id = eid; t.e_data = ed; t.e_ovf = eo;
    t.e_ops = eops; t.e_in1 = ei1; t.e_in2 = ei2;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic rdy);
    rst           = r;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepts;
    bit done;

    // rst, valid, a, b, rdy | req_ready, rsp_v, id, data, ovf, ops, in1, in2
    vecs[0]  = mk(1, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 8'h00, 0, 16'd0, 4'h0, 4'h0);
    vecs[1]  = mk(1, 4'b1111, 16'h000D, 16'h000B, 1, 4'b0000, 0, 0, 8'h00, 0, 16'd0, 4'h0, 4'h0);
    vecs[2]  = mk(0, 4'b0001, 16'h000D, 16'h000B, 1, 4'b0001, 0, 0, 8'h00, 0, 16'd0, 4'h0, 4'h0);
    vecs[3]  = mk(0, 4'b0000, 16'h000D, 16'h000B, 1, 4'b0000, 0, 0, 8'h00, 0, 16'd0, 4'hD, 4'hB);
    vecs[4]  = mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 0, 8'h8F, 1, 16'd0, 4'h0, 4'h0);
    vecs[5]  = mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 8'h8F, 1, 16'd1, 4'h0, 4'h0);
    vecs[6]  = mk(1, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 8'h8F, 1, 16'd1, 4'h0, 4'h0);
    vecs[7]  = mk(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0001, 0, 0, 8'h00, 0, 16'd0, 4'h0, 4'h0);
    vecs[8]  = mk(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0010, 0, 0, 8'h00, 0, 16'd0, 4'h1, 4'hF);
    vecs[9]  = mk(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0100, 1, 0, 8'h0F, 0, 16'd0, 4'h2, 4'hF);
    vecs[10] = mk(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b1000, 1, 1, 8'h1E, 1, 16'd1, 4'h3, 4'hF);
    vecs[11] = mk(0, 4'b1111, 16'h4321, 16'hFFFF, 1, 4'b0001, 1, 2, 8'h2D, 1, 16'd2, 4'h4, 4'hF);
    vecs[12] = mk(0, 4'b0000, 16'h4321, 16'hFFFF, 1, 4'b0000, 1, 3, 8'h3C, 1, 16'd3, 4'h1, 4'hF);
    vecs[13] = mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 0, 8'h0F, 0, 16'd4, 4'h0, 4'h0);
    vecs[14] = mk(0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000, 0, 0, 8'h0F, 0, 16'd5, 4'h0, 4'h0);
    vecs[15] = mk(0, 4'b0110, 16'h02F0, 16'h03F0, 0, 4'b0010, 0, 0, 8'h0F, 0, 16'd5, 4'h0, 4'h0);
    vecs[16] = mk(0, 4'b0110, 16'h02F0, 16'h03F0, 0, 4'b0100, 0, 0, 8'h0F, 0, 16'd5, 4'hF, 4'hF);
    vecs[17] = mk(0, 4'b0110, 16'h02F0, 16'h03F0, 0, 4'b0000, 1, 1, 8'hE1, 1, 16'd5, 4'h2, 4'h3);
    vecs[18] = mk(0, 4'b0110, 16'h02F0, 16'h03F0, 0, 4'b0000, 1, 1, 8'hE1, 1, 16'd5, 4'h2, 4'h3);
    vecs[19] = mk(0, 4'b0110, 16'h02F0, 16'h03F0, 1, 4'b0010, 1, 1, 8'hE1, 1, 16'd5, 4'h2, 4'h3);
    vecs[20] = mk(0, 4'b0000, 16'h02F0, 16'h03F0, 1, 4'b0000, 1, 2, 8'h06, 0, 16'd6, 4'hF, 4'hF);
    vecs[21] = mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 1, 8'hE1, 1, 16'd7, 4'h0, 4'h0);
    vecs[22] = mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 1, 8'hE1, 1, 16'd8, 4'h0, 4'h0);

    drive(1, 4'b0000, 16'h0, 16'h0, 1);
    next_cycle();
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy);
      @(negedge clk);
      chk("req_ready",    i, 32'(bus.req_ready),    32'(vecs[i].e_ready));
      chk("rsp_valid",    i, 32'(bus.rsp_valid),    32'(vecs[i].e_v));
      chk("rsp_id",       i, 32'(bus.rsp_id),       32'(vecs[i].e_id));
      chk("rsp_data",     i, 32'(bus.rsp_data),     32'(vecs[i].e_data));
      chk("rsp_overflow", i, 32'(bus.rsp_overflow), 32'(vecs[i].e_ovf));
      chk("ops_done",     i, 32'(bus.ops_done),     32'(vecs[i].e_ops));
      chk("mul_in1",      i, 32'(bus.mul_in1),      32'(vecs[i].e_in1));
      chk("mul_in2",      i, 32'(bus.mul_in2),      32'(vecs[i].e_in2));
      next_cycle();
    end

    // Reset one cycle after a handshake: the in-flight op must vanish.
    drive(0, 4'b0100, 16'h0500, 16'h0500, 1);
    @(negedge clk);
    chk("rmf_ready", 100, 32'(bus.req_ready), 32'h4);
    next_cycle();
    drive(1, 4'b0000, 16'h0, 16'h0, 1);
    @(negedge clk);
    chk("rmf_in1", 101, 32'(bus.mul_in1), 32'h5);
    next_cycle();
    drive(0, 4'b0000, 16'h0, 16'h0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rmf_rsp_valid", 102 + k, 32'(bus.rsp_valid), 32'h0);
      chk("rmf_ops_done",  102 + k, 32'(bus.ops_done),  32'h0);
      next_cycle();
    end
    drive(0, 4'b1111, 16'h1111, 16'h1111, 1);
    @(negedge clk);
    chk("rmf_grant0", 110, 32'(bus.req_ready), 32'h1);

    // Counter wrap: 65536 back-to-back ops from requester 0.
    drive(1, 4'b0000, 16'h0, 16'h0, 1);
    next_cycle();
    drive(0, 4'b0001, 16'h0003, 16'h0005, 1);
    accepts = 0;
    done    = 1'b0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) accepts++;
      next_cycle();
      if (accepts == 65536) begin
        done          = 1'b1;
        bus.req_valid = 4'b0000;
      end
    end
    chk("wrap_accepts", 200, 32'(accepts), 32'd65536);
    next_cycle();
    @(negedge clk);
    chk("wrap_ops_ffff",  201, 32'(bus.ops_done),  32'hFFFF);
    chk("wrap_last_v",    201, 32'(bus.rsp_valid), 32'h1);
    chk("wrap_last_data", 201, 32'(bus.rsp_data),  32'h0F);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrap_ops_zero",  202 + k, 32'(bus.ops_done),  32'h0);
      chk("idle_rsp_valid", 202 + k, 32'(bus.rsp_valid), 32'h0);
      chk("idle_in1",       202 + k, 32'(bus.mul_in1),   32'h0);
      chk("idle_in2",       202 + k, 32'(bus.mul_in2),   32'h0);
      chk("idle_ready",     202 + k, 32'(bus.req_ready), 32'h0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one combinational `dadda_*` multiplier instance among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning pair and drives it into the multiplier's `in1`/`in2`. It captures the product and overflow one cycle later and returns them on a single response channel, tagged with the requester ID and subject to backpressure. It sits between the client logic and the multiplier instance, which connects through the multiplier-side signals of `if_multiplier`.

## Interface
- `WIDTH`, 4, operand width; must match the shared multiplier.
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`, requester-ID width.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in `NREQ` — requester i has an operand pair.
- `req_ready` out `NREQ` — one-hot or zero; handshake completes where `req_valid[i] & req_ready[i]`.
- `req_a` in `NREQ`×`WIDTH` — multiplicand per requester.
- `req_b` in `NREQ`×`WIDTH` — multiplier operand per requester.
- `mul_in1` out `WIDTH` — to the multiplier's `in1`.
- `mul_in2` out `WIDTH` — to the multiplier's `in2`.
- `mul_out` in `2*WIDTH` — the multiplier's `out` (combinational).
- `mul_overflow` in 1 — the multiplier's `overflow`.
- `rsp_valid` out 1 — a response is held.
- `rsp_ready` in 1 — the consumer accepts the response.
- `rsp_id` out `IDW` — index of the requester that owns the response.
- `rsp_data` out `2*WIDTH` — product.
- `rsp_overflow` out 1 — captured overflow flag.
- `ops_done` out 16 — count of delivered responses; wraps 0xFFFF→0.

## Operation
- **Pipeline:** two registered stages.
  - Stage 1 (EXEC) holds the operand registers `op_a`/`op_b`/`op_id`, which drive `mul_in1`/`mul_in2` directly.
  - Stage 2 is the response register.
- **Stage-1 FSM:**
  - **IDLE**: no operation in flight; `mul_in1`/`mul_in2` drive 0. On an accepted request → EXEC.
  - **EXEC**: operands are held on the multiplier.
  - Define `stall = rsp_valid & ~rsp_ready`.
  - If `~stall`, capture `mul_out`/`mul_overflow`/`op_id` into the response register, then:
    - if a new request is accepted in the same cycle, stay in EXEC with the new operands;
    - otherwise go to IDLE.
  - If `stall`, stay in EXEC with the operands unchanged.
- **Acceptance:** `can_accept = (state==IDLE) | ~stall`.
  - `req_ready[g] = can_accept & grant[g]`; all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `state`, `rsp_valid`, `rsp_ready` and the pointer.
- **Round-robin grant:**
  - Pointer `last` holds the ID of the most recent accepted requester.
  - Search order is `last+1`, `last+2`, … mod `NREQ`; the first asserted `req_valid` wins.
  - `last` updates only on a completed handshake.
  - A requester that holds `req_valid` is granted within `NREQ` accepted transactions.
- **Response register:**
  - Loaded as described under the FSM.
  - `rsp_valid` clears when `rsp_ready` is high and no new load happens in that cycle.
  - A simultaneous drain and load keeps `rsp_valid` high with the new contents.
  - Outputs are stable while `rsp_valid & ~rsp_ready`.
- **`ops_done`:** increments on each cycle with `rsp_valid & rsp_ready`.
- **Arithmetic:** the product is unsigned `WIDTH`×`WIDTH` → `2*WIDTH` bits, taken unmodified from `mul_out`. The block does not check or correct it; approximate multipliers are allowed.
- **Reset values:**
  - State IDLE; `op_a`/`op_b`/`op_id` = 0; `last` = `NREQ-1`, so requester 0 has first priority.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_overflow` = 0, `ops_done` = 0.
  - `req_ready` = 0 while `rst` is high.
- **Reset mid-operation:** in-flight and held results are discarded, and no response is emitted for them.

## Timing
- **Latency:** handshake at edge N → `rsp_valid` high after edge N+1. That is two cycles from the request cycle to the first response-visible cycle.
- **Throughput:** one operation per cycle while `rsp_ready` stays high.
- **Backpressure:**
  - When `rsp_ready` is low with a response held, one further op may sit in EXEC.
  - `req_ready` goes all-zero until the response drains.
  - Maximum ops buffered: 2.
- **Multiplier path:** `mul_in1`/`mul_in2` come from flops, and `mul_out` is sampled one cycle later. The multiplier's combinational delay must fit in one clock period.

## Test plan
- **Single op:** after reset, req0 with a=13, b=11 held valid → `req_ready[0]` high in the same cycle; two cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0x8F (exact multiplier model); `ops_done`=1 after `rsp_ready`.
- **Fairness:** all four requesters are continuously valid with a=i+1, b=15, and `rsp_ready`=1 → grant order 0,1,2,3,0,… with one accept per cycle; `rsp_data` sequence 0x0F, 0x1E, 0x2D, 0x3C.
- **Backpressure:** hold `rsp_ready`=0 with req1 (15×15) and req2 (2×3) valid → exactly two accepts, then `req_ready`=0; `rsp_data`=0xE1 stays stable. Raise `rsp_ready` → 0xE1 then 0x06 on consecutive cycles, then accepts resume.
- **Simultaneous drain and load:** response held, `rsp_ready`=1 and a new EXEC result in the same cycle → `rsp_valid` stays 1, data is replaced, and `ops_done` increments by 1.
- **Reset mid-flight:** assert `rst` one cycle after a handshake → no response ever appears; `ops_done`=0; the next grant goes to requester 0.
- **Wrap and idle:** 65536 delivered responses → `ops_done` returns to 0; with no `req_valid`, the FSM stays IDLE and `mul_in1`/`mul_in2` = 0.
